osd_menu_ctrl: RTL and testbench

Menu controller between the IR key decoder and the local-dimming and OSD datapath. It turns single-cycle key codes into a browse/edit menu state machine and keeps a working copy of the backlight configuration. Committed configuration is applied to the processing chain only at a frame boundary. It also drives `osd_code` for the OSD overlay renderer and hides the menu after a programmable number of idle frames.

---
 rtl/osd_pkg.sv | 69 ++++++
 rtl/osd_cfg_shadow.sv | 97 +++++++++
 rtl/osd_menu_ctrl.sv | 142 ++++++++++++++
 tb/tb_osd_menu_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// Shared definitions for the OSD menu controller: key codes, menu states,
// backlight configuration record and the osd_code field layout.
package osd_pkg;

    localparam logic [7:0] KEY_MENU  = 8'h45;
    localparam logic [7:0] KEY_UP    = 8'h46;
    localparam logic [7:0] KEY_DOWN  = 8'h15;
    localparam logic [7:0] KEY_LEFT  = 8'h44;
    localparam logic [7:0] KEY_RIGHT = 8'h43;
    localparam logic [7:0] KEY_OK    = 8'h40;

    localparam int unsigned NUM_LINES = 5;
    localparam int unsigned LINE_W    = 3;
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);

    localparam int unsigned OSD_W         = 20;
    localparam int unsigned OSD_VIS       = 19;
    localparam int unsigned OSD_EDIT      = 18;
    localparam int unsigned OSD_SEL_LSB   = 15;
    localparam int unsigned OSD_GAMMA     = 14;
    localparam int unsigned OSD_LDIDX_LSB = 12;
    localparam int unsigned OSD_LDEN_LSB  = 9;
    localparam int unsigned OSD_SPA_ON    = 8;
    localparam int unsigned OSD_DATA_LSB  = 4;
    localparam int unsigned OSD_SPA_LSB   = 0;

    typedef enum logic [1:0] {
        HIDDEN = 2'd0,
        BROWSE = 2'd1,
        EDIT   = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] ld_idx;
        logic [2:0] ld_en;
        logic [1:0] spa_idx;
        logic [1:0] data_mode;
        logic       gamma_on;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{ld_idx: 2'd0, ld_en: 3'b111, spa_idx: 2'd1,
                                   data_mode: 2'd0, gamma_on: 1'b1};

    // Step a 0..2 value by one in either direction, wrapping.
    function automatic logic [1:0] wrap3(input logic [1:0] v, input logic inc);
        logic [1:0] r;
        if (inc) r = (v >= 2'd2) ? 2'd0 : v + 2'd1;
        else     r = (v == 2'd0) ? 2'd2 : v - 2'd1;
        return r;
    endfunction

    function automatic logic [OSD_W-1:0] osd_pack(input state_e st,
                                                   input logic [LINE_W-1:0] sel,
                                                   input cfg_t c);
        logic [OSD_W-1:0] o;
        o = '0;
        o[OSD_VIS]                = (st != HIDDEN);
        o[OSD_EDIT]               = (st == EDIT);
        o[OSD_SEL_LSB +: LINE_W]  = sel;
        o[OSD_GAMMA]              = c.gamma_on;
        o[OSD_LDIDX_LSB +: 2]     = c.ld_idx;
        o[OSD_LDEN_LSB +: 3]      = c.ld_en;
        o[OSD_SPA_ON]             = (c.spa_idx != 2'd0);
        o[OSD_DATA_LSB +: 4]      = 4'(c.data_mode);
        o[OSD_SPA_LSB +: 4]       = 4'(c.spa_idx);
        return o;
    endfunction

endpackage

// File: rtl/osd_cfg_shadow.sv
// Committed/active configuration pair: OK commits mark the set dirty and the
// next frame boundary applies it to the mapped processing-chain outputs.
module osd_cfg_shadow
    import osd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_1st_pxl,
    input  logic       commit,
    input  cfg_t       commit_cfg,
    output cfg_t       committed,
    output logic [1:0] LD_mode,
    output logic [2:0] LD_mode_en,
    output logic       gamma_bypass,
    output logic       SPA_bypass,
    output logic [3:0] SPA_mode,
    output logic [3:0] Data_mode,
    output logic       cfg_update
);

    cfg_t       committed_q, committed_d;
    logic       dirty_q, dirty_d;
    logic [1:0] ld_mode_q, ld_mode_d;
    logic [2:0] ld_mode_en_q, ld_mode_en_d;
    logic       gamma_bypass_q, gamma_bypass_d;
    logic       spa_bypass_q, spa_bypass_d;
    logic [3:0] spa_mode_q, spa_mode_d;
    logic [3:0] data_mode_q, data_mode_d;
    logic       cfg_update_q, cfg_update_d;

    // Apply samples the pre-commit dirty flag, so a same-cycle OK waits a frame.
    always_comb begin
        committed_d    = committed_q;
        dirty_d        = dirty_q;
        ld_mode_d      = ld_mode_q;
        ld_mode_en_d   = ld_mode_en_q;
        gamma_bypass_d = gamma_bypass_q;
        spa_bypass_d   = spa_bypass_q;
        spa_mode_d     = spa_mode_q;
        data_mode_d    = data_mode_q;
        cfg_update_d   = 1'b0;

        if (frame_1st_pxl && dirty_q) begin
            dirty_d      = 1'b0;
            cfg_update_d = 1'b1;
            case (committed_q.ld_idx)
                2'd1:    ld_mode_d = 2'b10;
                2'd2:    ld_mode_d = 2'b01;
                default: ld_mode_d = 2'b00;
            endcase
            ld_mode_en_d   = committed_q.ld_en;
            spa_bypass_d   = (committed_q.spa_idx == 2'd0);
            spa_mode_d     = (committed_q.spa_idx == 2'd2) ? 4'b0001 : 4'b0000;
            data_mode_d    = 4'(committed_q.data_mode);
            gamma_bypass_d = ~committed_q.gamma_on;
        end

        if (commit) begin
            committed_d = commit_cfg;
            dirty_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            committed_q    <= CFG_RESET;
            dirty_q        <= 1'b0;
            ld_mode_q      <= 2'b00;
            ld_mode_en_q   <= 3'b111;
            gamma_bypass_q <= 1'b0;
            spa_bypass_q   <= 1'b0;
            spa_mode_q     <= 4'b0000;
            data_mode_q    <= 4'b0000;
            cfg_update_q   <= 1'b0;
        end else begin
            committed_q    <= committed_d;
            dirty_q        <= dirty_d;
            ld_mode_q      <= ld_mode_d;
            ld_mode_en_q   <= ld_mode_en_d;
            gamma_bypass_q <= gamma_bypass_d;
            spa_bypass_q   <= spa_bypass_d;
            spa_mode_q     <= spa_mode_d;
            data_mode_q    <= data_mode_d;
            cfg_update_q   <= cfg_update_d;
        end
    end

    assign committed    = committed_q;
    assign LD_mode      = ld_mode_q;
    assign LD_mode_en   = ld_mode_en_q;
    assign gamma_bypass = gamma_bypass_q;
    assign SPA_bypass   = spa_bypass_q;
    assign SPA_mode     = spa_mode_q;
    assign Data_mode    = data_mode_q;
    assign cfg_update   = cfg_update_q;

endmodule

// File: rtl/osd_menu_ctrl.sv
// IR-key driven browse/edit menu with idle auto-hide; owns the working
// configuration and hands commits to the frame-synchronous shadow.
module osd_menu_ctrl
    import osd_pkg::*;
#(
    parameter int unsigned TIMEOUT_FRAMES = 600
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       order,
    input  logic             order_en,
    input  logic             frame_1st_pxl,
    output logic [OSD_W-1:0] osd_code,
    output logic [1:0]       LD_mode,
    output logic [2:0]       LD_mode_en,
    output logic             gamma_bypass,
    output logic             SPA_bypass,
    output logic [3:0]       SPA_mode,
    output logic [3:0]       Data_mode,
    output logic             cfg_update
);

    localparam int unsigned TW = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;

    state_e            state_q, state_d;
    logic [LINE_W-1:0] sel_q, sel_d;
    cfg_t              work_q, work_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [OSD_W-1:0]  osd_code_q, osd_code_d;
    logic              key_acc_c;
    logic              timeout_c;
    logic              commit_c;
    cfg_t              committed;

    assign timeout_c = (TIMEOUT_FRAMES != 0) && (state_q != HIDDEN) && frame_1st_pxl &&
                       ((32'(timer_q) + 32'd1) >= TIMEOUT_FRAMES);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        work_d    = work_q;
        timer_d   = timer_q;
        key_acc_c = 1'b0;
        commit_c  = 1'b0;

        if (state_q != HIDDEN && frame_1st_pxl && 32'(timer_q) != TIMEOUT_FRAMES)
            timer_d = timer_q + TW'(1);

        if (order_en) begin
            case (state_q)
                HIDDEN: begin
                    if (order == KEY_MENU) begin
                        key_acc_c = 1'b1;
                        state_d   = BROWSE;
                    end
                end
                BROWSE: begin
                    key_acc_c = 1'b1;
                    case (order)
                        KEY_UP:   sel_d = (sel_q == '0) ? LAST_LINE : sel_q - LINE_W'(1);
                        KEY_DOWN: sel_d = (sel_q >= LAST_LINE) ? '0 : sel_q + LINE_W'(1);
                        KEY_OK:   state_d = EDIT;
                        KEY_MENU: state_d = HIDDEN;
                        default:  key_acc_c = 1'b0;
                    endcase
                end
                EDIT: begin
                    key_acc_c = 1'b1;
                    case (order)
                        KEY_LEFT, KEY_RIGHT: begin
                            case (sel_q)
                                3'd0: work_d.ld_idx = wrap3(work_q.ld_idx, order == KEY_RIGHT);
                                3'd1: work_d.ld_en  = (order == KEY_RIGHT) ? work_q.ld_en + 3'd1
                                                                           : work_q.ld_en - 3'd1;
                                3'd2: work_d.spa_idx = wrap3(work_q.spa_idx, order == KEY_RIGHT);
                                3'd3: work_d.data_mode = (order == KEY_RIGHT) ? work_q.data_mode + 2'd1
                                                                              : work_q.data_mode - 2'd1;
                                default: work_d.gamma_on = ~work_q.gamma_on;
                            endcase
                        end
                        KEY_OK: begin
                            commit_c = 1'b1;
                            state_d  = BROWSE;
                        end
                        KEY_MENU: begin
                            work_d  = committed;
                            state_d = BROWSE;
                        end
                        default: key_acc_c = 1'b0;
                    endcase
                end
                default: state_d = HIDDEN;
            endcase
        end

        // An accepted key outranks a coincident timeout pulse.
        if (key_acc_c) begin
            timer_d = '0;
        end else if (timeout_c) begin
            state_d = HIDDEN;
            work_d  = committed;
            timer_d = '0;
        end

        osd_code_d = osd_pack(state_d, sel_d, work_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HIDDEN;
            sel_q      <= '0;
            work_q     <= CFG_RESET;
            timer_q    <= '0;
            osd_code_q <= osd_pack(HIDDEN, '0, CFG_RESET);
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            work_q     <= work_d;
            timer_q    <= timer_d;
            osd_code_q <= osd_code_d;
        end
    end

    assign osd_code = osd_code_q;

    osd_cfg_shadow u_shadow (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_1st_pxl(frame_1st_pxl),
        .commit       (commit_c),
        .commit_cfg   (work_q),
        .committed    (committed),
        .LD_mode      (LD_mode),
        .LD_mode_en   (LD_mode_en),
        .gamma_bypass (gamma_bypass),
        .SPA_bypass   (SPA_bypass),
        .SPA_mode     (SPA_mode),
        .Data_mode    (Data_mode),
        .cfg_update   (cfg_update)
    );

endmodule

// File: tb/tb_osd_menu_ctrl.sv
// Directed bench for osd_menu_ctrl with a 4-frame idle timeout.
module tb_osd_menu_ctrl;

    localparam logic [7:0] K_MENU  = 8'h45;
    localparam logic [7:0] K_UP    = 8'h46;
    localparam logic [7:0] K_DOWN  = 8'h15;
    localparam logic [7:0] K_LEFT  = 8'h44;
    localparam logic [7:0] K_RIGHT = 8'h43;
    localparam logic [7:0] K_OK    = 8'h40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  order = 8'h00;
    logic        order_en = 1'b0;
    logic        frame_1st_pxl = 1'b0;
    logic [19:0] osd_code;
    logic [1:0]  LD_mode;
    logic [2:0]  LD_mode_en;
    logic        gamma_bypass;
    logic        SPA_bypass;
    logic [3:0]  SPA_mode;
    logic [3:0]  Data_mode;
    logic        cfg_update;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;

    osd_menu_ctrl #(.TIMEOUT_FRAMES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .order        (order),
        .order_en     (order_en),
        .frame_1st_pxl(frame_1st_pxl),
        .osd_code     (osd_code),
        .LD_mode      (LD_mode),
        .LD_mode_en   (LD_mode_en),
        .gamma_bypass (gamma_bypass),
        .SPA_bypass   (SPA_bypass),
        .SPA_mode     (SPA_mode),
        .Data_mode    (Data_mode),
        .cfg_update   (cfg_update)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cfg_update === 1'b1) upd_cnt <= upd_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus; returns just after the following falling edge.
    task automatic step(input logic [7:0] k, input logic en, input logic fr);
        @(negedge clk);
        order = k; order_en = en; frame_1st_pxl = fr;
        @(negedge clk);
        order_en = 1'b0; frame_1st_pxl = 1'b0;
        #1;
    endtask

    task automatic press(input logic [7:0] k);
        step(k, 1'b1, 1'b0);
    endtask

    task automatic frame();
        step(8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset defaults
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_osd", 32'(osd_code), 32'h04F01);
        chk("rst_ld_mode", 32'(LD_mode), 32'h0);
        chk("rst_ld_en", 32'(LD_mode_en), 32'h7);
        chk("rst_spa", 32'({SPA_bypass, SPA_mode}), 32'h00);
        chk("rst_data_gamma", 32'({Data_mode, gamma_bypass}), 32'h00);
        chk("rst_cfg_update", 32'(cfg_update), 32'h0);
        repeat (3) frame();
        press(K_UP);
        chk("idle_osd", 32'(osd_code), 32'h04F01);
        chk("idle_upd", 32'(upd_cnt), 32'd0);

        // Edit and apply on line 3
        press(K_MENU);
        chk("menu_open", 32'(osd_code), 32'h84F01);
        repeat (3) press(K_DOWN);
        press(K_OK);
        press(K_RIGHT);
        chk("edit_data", 32'(osd_code), 32'hDCF11);
        press(K_OK);
        chk("commit_osd", 32'(osd_code), 32'h9CF11);
        chk("pre_apply_data", 32'(Data_mode), 32'h0);
        frame();
        chk("apply_data", 32'(Data_mode), 32'h1);
        chk("apply_pulse", 32'(cfg_update), 32'h1);
        press(8'h00);
        chk("apply_once", 32'(upd_cnt), 32'd1);

        // Reset during an edit restores everything without a pulse
        press(K_MENU);
        press(K_MENU);
        press(K_OK);
        press(K_RIGHT);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_osd", 32'(osd_code), 32'h04F01);
        chk("mid_rst_data", 32'(Data_mode), 32'h0);
        press(8'h00);
        chk("mid_rst_upd", 32'(upd_cnt), 32'd1);

        // Line wrap to 4 and gamma toggle
        press(K_MENU);
        press(K_UP);
        chk("wrap_sel4", 32'(osd_code), 32'hA4F01);
        press(K_OK);
        press(K_LEFT);
        chk("gamma_off", 32'(osd_code), 32'hE0F01);
        press(K_OK);
        frame();
        chk("gamma_bypass", 32'(gamma_bypass), 32'h1);

        // Discard on line 0
        press(K_DOWN);
        chk("wrap_sel0", 32'(osd_code), 32'h80F01);
        press(K_OK);
        press(K_RIGHT);
        press(K_RIGHT);
        chk("ld_idx2", 32'(osd_code), 32'hC2F01);
        press(K_MENU);
        chk("discard_osd", 32'(osd_code), 32'h80F01);
        frame();
        chk("discard_ld", 32'(LD_mode), 32'h0);
        chk("discard_upd", 32'(upd_cnt), 32'd2);

        // Idle timeout after 4 frames
        press(K_MENU);
        press(K_MENU);
        press(K_OK);
        press(K_RIGHT);
        repeat (3) frame();
        chk("to_3frames", 32'(osd_code), 32'hC1F01);
        frame();
        chk("to_hidden", 32'(osd_code), 32'h00F01);

        // Key on frame 3 restarts the timer
        press(K_MENU);
        press(K_OK);
        press(K_RIGHT);
        repeat (2) frame();
        step(K_RIGHT, 1'b1, 1'b1);
        frame();
        chk("to_key_wins", 32'(osd_code), 32'hC2F01);
        press(K_MENU);

        // OK coincident with the frame pulse applies one frame later
        press(K_OK);
        press(K_RIGHT);
        step(K_OK, 1'b1, 1'b1);
        chk("coll_ld", 32'(LD_mode), 32'h0);
        chk("coll_noupd", 32'(cfg_update), 32'h0);
        frame();
        chk("coll_apply", 32'(LD_mode), 32'h2);
        press(8'h00);
        chk("coll_upd", 32'(upd_cnt), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
